// File: rtl/grn_pkg.sv
// Shared definitions for the gene-regulatory-network node: update-function
// encodings and the population count used by the majority function.
package grn_pkg;

  typedef enum logic [1:0] {
    MODE_COPY = 2'b00,
    MODE_AND  = 2'b01,
    MODE_OR   = 2'b10,
    MODE_MAJ  = 2'b11
  } mode_e;

  localparam int MAX_IN = 8;

  function automatic logic [3:0] popcount(input logic [MAX_IN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_IN; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/grn_node_multi_if.sv
// Control/data bundle of grn_node_multi: the network driver is the master,
// the node array is the slave.
interface grn_node_multi_if #(
  parameter int NUM_CH = 2,
  parameter int NUM_IN = 4,
  parameter int DIV_W  = 4
);
  logic                       reset_nos;
  logic [NUM_CH-1:0]          init_state;
  logic [NUM_CH*DIV_W-1:0]    period;
  grn_pkg::mode_e             mode;
  logic [NUM_IN-1:0]          act_mask;
  logic [NUM_CH-1:0]          start;
  logic [NUM_CH*NUM_IN-1:0]   reg_in;
  logic [NUM_CH-1:0]          s;
  logic [NUM_CH-1:0]          changed;
  logic [NUM_CH-1:0]          stable;

  modport master (
    output reset_nos, init_state, period, mode, act_mask, start, reg_in,
    input  s, changed, stable
  );

  modport slave (
    input  reset_nos, init_state, period, mode, act_mask, start, reg_in,
    output s, changed, stable
  );
endinterface

// File: rtl/grn_node_ch.sv
// One network node: update divider, Boolean update function, state and
// change flag; stability counter only when GRN_NODE_STABLE_EN is defined.
module grn_node_ch
  import grn_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int DIV_W     = 4,
  parameter int STABLE_TH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset_nos_i,
  input  logic              init_i,
  input  logic [DIV_W-1:0]  period_i,
  input  mode_e             mode_i,
  input  logic [NUM_IN-1:0] act_mask_i,
  input  logic              start_i,
  input  logic [NUM_IN-1:0] reg_in_i,
  output logic              s_o,
  output logic              changed_o,
  output logic              stable_o
);

  if (NUM_IN < 1 || NUM_IN > MAX_IN || STABLE_TH < 1) begin : g_param_err
    $error("grn_node_ch: NUM_IN must be 1..8 and STABLE_TH >= 1");
  end

  logic [NUM_IN-1:0] lit;
  logic [MAX_IN-1:0] act_hi, inh_hi;
  logic              f;

  // Activators pass through, inhibitors are inverted.
  assign lit    = reg_in_i ~^ act_mask_i;
  assign act_hi = MAX_IN'(reg_in_i & act_mask_i);
  assign inh_hi = MAX_IN'(reg_in_i & ~act_mask_i);

  always_comb begin
    f = reg_in_i[0];
    case (mode_i)
      MODE_COPY: f = reg_in_i[0];
      MODE_AND:  f = &lit;
      MODE_OR:   f = |lit;
      MODE_MAJ:  f = popcount(act_hi) > popcount(inh_hi);
    endcase
  end

  logic             s_q, s_d, chg_q, chg_d, upd;
  logic [DIV_W-1:0] cnt_q, cnt_d, p_q, p_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    upd   = 1'b0;
    if (reset_nos_i) begin
      s_d   = init_i;
      cnt_d = '0;
      p_d   = period_i;
    end else if (start_i) begin
      if (cnt_q == '0) begin
        upd   = 1'b1;
        s_d   = f;
        cnt_d = p_q;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
    chg_d = upd && (f != s_q);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= 1'b0;
      chg_q <= 1'b0;
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      s_q   <= s_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  assign s_o       = s_q;
  assign changed_o = chg_q;

`ifdef GRN_NODE_STABLE_EN
  localparam int SW = $clog2(STABLE_TH + 1);
  localparam logic [SW-1:0] TH = SW'(STABLE_TH);

  logic [SW-1:0] stab_q, stab_d;

  always_comb begin
    stab_d = stab_q;
    if (reset_nos_i || chg_d) stab_d = '0;
    else if (upd && stab_q != TH) stab_d = stab_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stab_q <= '0;
    else     stab_q <= stab_d;
  end

  assign stable_o = (stab_q == TH);
`else
  assign stable_o = 1'b0;
`endif

endmodule

// File: rtl/grn_node_multi.sv
// Array of NUM_CH independent GRN nodes sharing mode/act_mask.
// Optional stability detection enabled by defining GRN_NODE_STABLE_EN.
module grn_node_multi #(
  parameter int NUM_CH    = 2,
  parameter int NUM_IN    = 4,
  parameter int DIV_W     = 4,
  parameter int STABLE_TH = 8
) (
  input logic            clk,
  input logic            rst,
  grn_node_multi_if.slave bus
);

  logic [NUM_CH-1:0] s_w, chg_w, stab_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    grn_node_ch #(
      .NUM_IN    (NUM_IN),
      .DIV_W     (DIV_W),
      .STABLE_TH (STABLE_TH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .reset_nos_i (bus.reset_nos),
      .init_i      (bus.init_state[c]),
      .period_i    (bus.period[c*DIV_W +: DIV_W]),
      .mode_i      (bus.mode),
      .act_mask_i  (bus.act_mask),
      .start_i     (bus.start[c]),
      .reg_in_i    (bus.reg_in[c*NUM_IN +: NUM_IN]),
      .s_o         (s_w[c]),
      .changed_o   (chg_w[c]),
      .stable_o    (stab_w[c])
    );
  end

  assign bus.s       = s_w;
  assign bus.changed = chg_w;
  assign bus.stable  = stab_w;

endmodule

// File: tb/tb_grn_node_multi.sv
// Directed bench for grn_node_multi (2 channels x 4 inputs, DIV_W=4, STABLE_TH=8).
module tb_grn_node_multi;
  import grn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  grn_node_multi_if #(.NUM_CH(2), .NUM_IN(4), .DIV_W(4)) bus ();

  grn_node_multi #(
    .NUM_CH(2), .NUM_IN(4), .DIV_W(4), .STABLE_TH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef GRN_NODE_STABLE_EN
  localparam bit STAB_EN = 1'b1;
`else
  localparam bit STAB_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nos(input logic [1:0] init, input logic [7:0] per);
    bus.reset_nos  = 1'b1;
    bus.init_state = init;
    bus.period     = per;
    tick();
    bus.reset_nos  = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] st);
    bus.start = st;
    tick();
    bus.start = 2'b00;
  endtask

  initial begin
    rst            = 1'b1;
    bus.reset_nos  = 1'b0;
    bus.init_state = '0;
    bus.period     = '0;
    bus.mode       = MODE_COPY;
    bus.act_mask   = '0;
    bus.start      = '0;
    bus.reg_in     = '0;
    tick();
    tick();
    check("rst_s", 8'(bus.s), 8'h0);
    check("rst_changed", 8'(bus.changed), 8'h0);
    check("rst_stable", 8'(bus.stable), 8'h0);
    rst = 1'b0;
    tick();

    // Changed pulse in OR mode
    nos(2'b00, 8'h00);
    check("nos_s", 8'(bus.s), 8'h0);
    bus.mode = MODE_OR; bus.act_mask = 4'hF; bus.reg_in = 8'h01;
    pulse(2'b11);
    check("or_s", 8'(bus.s), 8'h1);
    check("or_changed", 8'(bus.changed), 8'h1);
    tick();
    check("or_changed_drop", 8'(bus.changed), 8'h0);
    pulse(2'b11);
    check("or_repeat_s", 8'(bus.s), 8'h1);
    check("or_repeat_changed", 8'(bus.changed), 8'h0);

    // Majority: ch0 2 act vs 1 inh, ch1 1 vs 2
    bus.mode = MODE_MAJ; bus.act_mask = 4'b0011; bus.reg_in = 8'hD7;
    pulse(2'b11);
    check("maj1_s", 8'(bus.s), 8'h1);
    check("maj1_changed", 8'(bus.changed), 8'h0);
    // ch0 tie -> 0, ch1 2 act vs 1 inh -> 1
    bus.reg_in = 8'h7F;
    pulse(2'b11);
    check("maj2_s", 8'(bus.s), 8'h2);
    check("maj2_changed", 8'(bus.changed), 8'h3);

    // Divider: ch0 period 0, ch1 period 1
    nos(2'b00, 8'h10);
    bus.mode = MODE_COPY;
    bus.reg_in = 8'h11; pulse(2'b11);
    check("div1_s", 8'(bus.s), 8'h3);
    check("div1_changed", 8'(bus.changed), 8'h3);
    bus.reg_in = 8'h00; pulse(2'b11);
    check("div2_s", 8'(bus.s), 8'h2);
    check("div2_changed", 8'(bus.changed), 8'h1);
    bus.reg_in = 8'h00; pulse(2'b11);
    check("div3_s", 8'(bus.s), 8'h0);
    check("div3_changed", 8'(bus.changed), 8'h2);
    bus.reg_in = 8'h11; pulse(2'b11);
    check("div4_s", 8'(bus.s), 8'h1);
    check("div4_changed", 8'(bus.changed), 8'h1);

    // Collision: start ignored when reset_nos is asserted
    bus.start = 2'b11;
    nos(2'b10, 8'h10);
    bus.start = 2'b00;
    check("coll_s", 8'(bus.s), 8'h2);
    check("coll_changed", 8'(bus.changed), 8'h0);
    bus.reg_in = 8'h01; pulse(2'b11);
    check("coll_next_s", 8'(bus.s), 8'h1);
    check("coll_next_changed", 8'(bus.changed), 8'h3);

    // Stability: eight quiet updates, then a change on ch0
    nos(2'b00, 8'h00);
    bus.reg_in = 8'h00;
    repeat (7) pulse(2'b11);
    check("stab_7", 8'(bus.stable), 8'h0);
    pulse(2'b11);
    check("stab_8", 8'(bus.stable), STAB_EN ? 8'h3 : 8'h0);
    pulse(2'b11);
    check("stab_sat", 8'(bus.stable), STAB_EN ? 8'h3 : 8'h0);
    bus.reg_in = 8'h01; pulse(2'b11);
    check("stab_change_s", 8'(bus.s), 8'h1);
    check("stab_change", 8'(bus.stable), STAB_EN ? 8'h2 : 8'h0);

    // Asynchronous reset mid-run with s = 2'b11
    bus.reg_in = 8'h11; pulse(2'b11);
    check("pre_rst_s", 8'(bus.s), 8'h3);
    check("pre_rst_changed", 8'(bus.changed), 8'h2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_s", 8'(bus.s), 8'h0);
    check("async_rst_changed", 8'(bus.changed), 8'h0);
    check("async_rst_stable", 8'(bus.stable), 8'h0);
    bus.start = 2'b11;
    tick();
    check("rst_start_ignored", 8'(bus.s), 8'h0);
    bus.start = 2'b00;
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
